monitor_contador: RTL and testbench



---
 rtl/monitor_contador_pkg.sv | 22 ++
 rtl/monitor_contador_buscador_indice.sv | 25 ++
 rtl/monitor_contador.sv | 139 +++++++++++++
 tb/tb_monitor_contador.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/monitor_contador_pkg.sv
// Shared definitions for the sequence monitor: FSM encoding, widths and index arithmetic.
package monitor_contador_pkg;

  localparam int unsigned EntryW   = 4;
  localparam int unsigned CountW   = 8;
  localparam logic [CountW-1:0] CountMax = 8'd255;

  typedef enum logic {
    StAcquire = 1'b0,
    StTrack   = 1'b1
  } state_e;

  // Position following k in a sequence of len entries.
  function automatic logic [EntryW-1:0] next_idx(input logic [EntryW-1:0] k,
                                                 input int unsigned len);
    if (32'(k) + 32'd1 >= len) begin
      return '0;
    end
    return k + EntryW'(1);
  endfunction

endpackage

// File: rtl/monitor_contador_buscador_indice.sv
// Combinational search of a sampled value in the programmed sequence table.
module monitor_contador_buscador_indice
  import monitor_contador_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 6,
  parameter logic [63:0] SEQ     = 64'h0000_0000_00FC_9530
) (
  input  logic [EntryW-1:0] q,
  output logic              hit,
  output logic [EntryW-1:0] index
);

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int k = int'(SEQ_LEN) - 1; k >= 0; k--) begin
      if (SEQ[4*k +: EntryW] == q) begin
        hit   = 1'b1;
        index = EntryW'(k);
      end
    end
  end

endmodule

// File: rtl/monitor_contador.sv
// Sequence monitor for the arbitrary counter: locks onto SEQ and reports errors and wrap.
// Define MONITOR_DISPLAY_EN to print error and lock events in simulation.
module monitor_contador
  import monitor_contador_pkg::*;
#(
  parameter int unsigned SEQ_LEN  = 6,
  parameter logic [63:0] SEQ      = 64'h0000_0000_00FC_9530,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic              C,
  input  logic              R,
  input  logic [EntryW-1:0] Q,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic [CountW-1:0] err_count,
  output logic [EntryW-1:0] idx,
  output logic              wrap
);

  localparam logic [EntryW-1:0] LockRun = EntryW'(LOCK_CNT);

  state_e              state_q, state_d;
  logic [EntryW-1:0]   exp_q, exp_d;
  logic [EntryW-1:0]   run_q, run_d;
  logic [EntryW-1:0]   idx_q, idx_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                sticky_q, sticky_d;
  logic [CountW-1:0]   cnt_q, cnt_d;
  logic                wrap_q, wrap_d;

  logic                hit;
  logic [EntryW-1:0]   hit_idx;
  logic [EntryW-1:0]   exp_val;

  monitor_contador_buscador_indice #(
    .SEQ_LEN (SEQ_LEN),
    .SEQ     (SEQ)
  ) u_buscador (
    .q     (Q),
    .hit   (hit),
    .index (hit_idx)
  );

  assign exp_val = SEQ[{exp_q, 2'b00} +: EntryW];

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    run_d    = run_q;
    idx_d    = idx_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    unique case (state_q)
      StAcquire: begin
        if (hit) begin
          state_d  = StTrack;
          idx_d    = hit_idx;
          exp_d    = next_idx(hit_idx, SEQ_LEN);
          run_d    = EntryW'(1);
          locked_d = (LOCK_CNT == 32'd1);
        end
      end
      StTrack: begin
        if (Q == exp_val) begin
          idx_d    = exp_q;
          exp_d    = next_idx(exp_q, SEQ_LEN);
          run_d    = (run_q >= LockRun) ? LockRun : run_q + EntryW'(1);
          locked_d = (run_d == LockRun);
          wrap_d   = (exp_q == '0) && (SEQ_LEN > 32'd1);
        end else begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          cnt_d    = (cnt_q == CountMax) ? cnt_q : cnt_q + CountW'(1);
          locked_d = 1'b0;
          // Resync on the same edge if the sample sits elsewhere in the table.
          if (hit) begin
            idx_d = hit_idx;
            exp_d = next_idx(hit_idx, SEQ_LEN);
            run_d = EntryW'(1);
          end else begin
            state_d = StAcquire;
            run_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q  <= StAcquire;
      exp_q    <= '0;
      run_q    <= '0;
      idx_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      idx_q    <= idx_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;
  assign idx        = idx_q;
  assign wrap       = wrap_q;

`ifdef MONITOR_DISPLAY_EN
  always @(posedge C) begin
    if (!R && err_d) begin
      $display("%0t monitor_contador: expected %h sampled %h err_count %0d",
               $time, exp_val, Q, cnt_d);
    end
    if (!R && locked_d && !locked_q) begin
      $display("%0t monitor_contador: locked", $time);
    end
  end
`else
  // Synthesizable build: no simulation reporting.
`endif

endmodule

// File: tb/tb_monitor_contador.sv
// Randomized bench for monitor_contador against a spec-level reference model.
module tb_monitor_contador;

  localparam int L  = 6;
  localparam int LC = 3;

  logic       C;
  logic       R;
  logic [3:0] Q;
  logic       locked, err, err_sticky, wrap;
  logic [7:0] err_count;
  logic [3:0] idx;

  int seq_tab[L] = '{0, 3, 5, 9, 12, 15};

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit m_track;
  int m_exp, m_run, m_idx, m_cnt;
  bit m_locked, m_err, m_sticky, m_wrap;

  monitor_contador #(
    .SEQ_LEN  (6),
    .SEQ      (64'h0000_0000_00FC_9530),
    .LOCK_CNT (3)
  ) dut (
    .C          (C),
    .R          (R),
    .Q          (Q),
    .locked     (locked),
    .err        (err),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .idx        (idx),
    .wrap       (wrap)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int find(input int v);
    for (int k = 0; k < L; k++) begin
      if (seq_tab[k] == v) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_track = 0; m_exp = 0; m_run = 0; m_idx = 0; m_cnt = 0;
    m_locked = 0; m_err = 0; m_sticky = 0; m_wrap = 0;
  endtask

  task automatic model_step(input int v);
    int j;
    j = find(v);
    m_err  = 0;
    m_wrap = 0;
    if (!m_track) begin
      if (j >= 0) begin
        m_track = 1; m_idx = j; m_exp = (j + 1) % L; m_run = 1; m_locked = (LC == 1);
      end
    end else if (v == seq_tab[m_exp]) begin
      m_wrap   = (m_exp == 0) && (L > 1);
      m_idx    = m_exp;
      m_exp    = (m_exp + 1) % L;
      m_run    = (m_run + 1 > LC) ? LC : m_run + 1;
      m_locked = (m_run == LC);
    end else begin
      m_err = 1; m_sticky = 1; m_locked = 0;
      m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      if (j >= 0) begin
        m_idx = j; m_exp = (j + 1) % L; m_run = 1;
      end else begin
        m_track = 0; m_run = 0;
      end
    end
  endtask

  always @(posedge C or posedge R) begin
    if (R) model_reset();
    else   model_step(int'(Q));
  end

  // Every-cycle comparison, away from the sampling edge.
  always @(negedge C) begin
    check("locked", int'(locked), int'(m_locked));
    check("err", int'(err), int'(m_err));
    check("err_sticky", int'(err_sticky), int'(m_sticky));
    check("err_count", int'(err_count), m_cnt);
    check("idx", int'(idx), m_idx);
    check("wrap", int'(wrap), int'(m_wrap));
    check("err_and_wrap", int'(err & wrap), 0);
  end

  // Called at a negedge: present v, return at the next negedge with outputs updated.
  task automatic feed(input int v);
    Q = 4'(v);
    @(negedge C);
  endtask

  task automatic do_reset();
    R = 1'b1;
    repeat (3) @(negedge C);
    R = 1'b0;
  endtask

  int ptr;
  int r;

  initial begin
    model_reset();
    R = 1'b1;
    Q = 4'd0;
    @(negedge C);
    check("reset_locked", int'(locked), 0);
    check("reset_count", int'(err_count), 0);
    repeat (2) @(negedge C);
    R = 1'b0;

    // Clean sequence
    feed(0); feed(3);
    check("pre_lock", int'(locked), 0);
    feed(5);
    check("lock_on_third", int'(locked), 1);
    check("idx_after_5", int'(idx), 2);
    feed(9); feed(12); feed(15);
    feed(0);
    check("wrap_after_0", int'(wrap), 1);
    feed(3); feed(5);

    // Single glitch: 7 instead of 9
    feed(7);
    check("glitch_err", int'(err), 1);
    check("glitch_count", int'(err_count), 1);
    check("glitch_unlock", int'(locked), 0);
    feed(12); feed(15); feed(0);
    check("relock", int'(locked), 1);
    check("sticky_held", int'(err_sticky), 1);

    // Resync: expecting F, see C
    feed(3); feed(5); feed(9); feed(12);
    feed(12);
    check("resync_err", int'(err), 1);
    check("resync_idx", int'(idx), 4);
    check("resync_count", int'(err_count), 2);
    feed(15);
    check("resync_ok", int'(err), 0);
    check("resync_idx5", int'(idx), 5);

    // Build err_count=4 while locked, then async reset between edges
    feed(3); feed(0); feed(3); feed(5);
    check("pre_rst_count", int'(err_count), 4);
    check("pre_rst_locked", int'(locked), 1);
    Q = 4'd9;
    @(posedge C);
    #2 R = 1'b1;
    #1;
    check("async_locked", int'(locked), 0);
    check("async_count", int'(err_count), 0);
    check("async_sticky", int'(err_sticky), 0);
    check("async_idx", int'(idx), 0);
    @(negedge C);
    R = 1'b0;

    // Unknown values in ACQUIRE
    feed(1); feed(2); feed(4);
    check("unknown_noerr", int'(err_count), 0);
    feed(0); feed(3); feed(5);
    check("acq_lock", int'(locked), 1);

    // Randomized run against the model
    ptr = 3;
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        Q = 4'(seq_tab[ptr]);
        ptr = (ptr + 1) % L;
      end else if (r == 7) begin
        Q = 4'($urandom_range(0, 15));
      end else if (r == 9) begin
        ptr = int'($urandom_range(0, L - 1));
      end
      @(negedge C);
    end

    // Stall and saturation
    do_reset();
    feed(0); feed(3); feed(5);
    for (int i = 0; i < 100; i++) feed(3);
    check("stall_100", int'(err_count), 100);
    for (int i = 0; i < 200; i++) feed(3);
    check("stall_sat", int'(err_count), 255);
    check("stall_err", int'(err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
